// File: rtl/sam_mouse_interface_pkg.sv
// Shared constants for the SAM Coupe mouse interface: nibble indices, PS/2 byte-0 bits, packet length.
// Optional build macro: MOUSE_WHEEL_EN (4-byte IntelliMouse packets, wheel nibble at the last index).
package sam_mouse_interface_pkg;

  localparam logic [3:0] IDX_HDR = 4'd0;
  localparam logic [3:0] IDX_BTN = 4'd1;
  localparam logic [3:0] IDX_Y2  = 4'd2;
  localparam logic [3:0] IDX_Y1  = 4'd3;
  localparam logic [3:0] IDX_Y0  = 4'd4;
  localparam logic [3:0] IDX_X2  = 4'd5;
  localparam logic [3:0] IDX_X1  = 4'd6;
  localparam logic [3:0] IDX_X0  = 4'd7;
  localparam logic [3:0] IDX_END = 4'd8;

  localparam int B0_BTN_L = 0;
  localparam int B0_BTN_R = 1;
  localparam int B0_BTN_M = 2;
  localparam int B0_SYNC  = 3;
  localparam int B0_XSIGN = 4;
  localparam int B0_YSIGN = 5;
  localparam int B0_XOVF  = 6;
  localparam int B0_YOVF  = 7;

`ifdef MOUSE_WHEEL_EN
  localparam int PKT_LEN = 4;
`else
  localparam int PKT_LEN = 3;
`endif

  localparam logic [3:0] NIB_IDLE = 4'hF;

  // An axis flagged as overflowed reports no motion for that packet.
  function automatic logic signed [8:0] axisDelta(input logic sign, input logic [7:0] mag,
                                                  input logic ovf);
    return ovf ? 9'sd0 : $signed({sign, mag});
  endfunction

endpackage

// File: rtl/sam_mouse_interface_ps2_mouse_packet.sv
// PS/2 mouse packet assembler: byte counter, byte-0 sync check, decoded deltas and buttons.
// Optional build macro: MOUSE_WHEEL_EN adds a fourth byte carrying a signed wheel delta.
module ps2_mouse_packet
  import sam_mouse_interface_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              pkt_done_o,
  output logic signed [8:0] dx_o,
  output logic signed [8:0] dy_o,
  output logic [2:0]        btn_o,
`ifdef MOUSE_WHEEL_EN
  output logic signed [3:0] wheel_o,
`endif
  output logic              sync_err_o
);

  localparam logic [1:0] CNT_LAST = 2'(PKT_LEN - 1);

  logic [1:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [7:0] b0_q;
  logic [7:0] b1_q;
  logic [7:0] yByte;
  logic       lastByte;

  assign lastByte = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (byte_valid_i) begin
      if ((cnt_q == 2'd0) && !byte_i[B0_SYNC]) begin
        err_d = 1'b1;
      end else if (lastByte) begin
        cnt_d = 2'd0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

`ifdef MOUSE_WHEEL_EN
  logic [7:0] b2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b2_q <= 8'h00;
    end else if (byte_valid_i && (cnt_q == 2'd2)) begin
      b2_q <= byte_i;
    end
  end

  assign yByte   = b2_q;
  assign wheel_o = $signed(byte_i[3:0]);
`else
  assign yByte = byte_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      err_q <= 1'b0;
      b0_q  <= 8'h00;
      b1_q  <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (byte_valid_i && (cnt_q == 2'd0)) b0_q <= byte_i;
      if (byte_valid_i && (cnt_q == 2'd1)) b1_q <= byte_i;
    end
  end

  // The last byte is used straight off the bus so the packet completes in its own cycle.
  assign pkt_done_o = byte_valid_i && lastByte && b0_q[B0_SYNC];
  assign dx_o       = axisDelta(b0_q[B0_XSIGN], b1_q, b0_q[B0_XOVF]);
  assign dy_o       = axisDelta(b0_q[B0_YSIGN], yByte, b0_q[B0_YOVF]);
  assign btn_o      = {b0_q[B0_BTN_M], b0_q[B0_BTN_R], b0_q[B0_BTN_L]};
  assign sync_err_o = err_q;

endmodule

// File: rtl/sam_mouse_interface.sv
// SAM Coupe mouse port: accumulates PS/2 motion and serves it as a nibble sequence on RDMSEL reads.
// Optional build macro: MOUSE_WHEEL_EN (wheel snapshot returned at the final index).
module sam_mouse_interface
  import sam_mouse_interface_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 600,
  parameter int ACC_W          = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  input  logic       rdmsel,
  output logic [3:0] mdata,
  output logic       packet_err
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  logic              pktDone;
  logic signed [8:0] dx, dy;
  logic [2:0]        btn;
  logic              syncErr;

  ps2_mouse_packet u_packet (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_i       (ps2_byte),
    .byte_valid_i (ps2_byte_valid),
    .pkt_done_o   (pktDone),
    .dx_o         (dx),
    .dy_o         (dy),
    .btn_o        (btn),
`ifdef MOUSE_WHEEL_EN
    .wheel_o      (wheel),
`endif
    .sync_err_o   (syncErr)
  );

  function automatic logic signed [ACC_W-1:0] satAdd(input logic signed [ACC_W-1:0] acc,
                                                     input logic signed [8:0] d);
    logic [ACC_W:0] sum;
    sum = {acc[ACC_W-1], acc} + {{(ACC_W-8){d[8]}}, d};
    if (sum[ACC_W] != sum[ACC_W-1]) return sum[ACC_W] ? ACC_MIN : ACC_MAX;
    return sum[ACC_W-1:0];
  endfunction

  function automatic logic [11:0] clampSnap(input logic signed [ACC_W-1:0] a);
    int v;
    v = int'(a);
    if (v > 2047) return 12'h7FF;
    if (v < -2048) return 12'h800;
    return v[11:0];
  endfunction

  logic signed [ACC_W-1:0] accX_q, accX_d, accY_q, accY_d;
  logic [2:0]              btn_q, btn_d;
  logic [11:0]             snapX_q, snapY_q;
  logic [2:0]              snapBtn_q;
  logic                    rdSync_q, rdDly_q, rdFall;
  logic [3:0]              idx_q, idx_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    firstAdv;
  logic [3:0]              mdata_q, mdata_d;
  logic                    err_q;

  assign rdFall = rdDly_q && !rdSync_q;

  // A read ending always wins over the timeout in the same cycle.
  always_comb begin
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    firstAdv = 1'b0;
    if (rdFall) begin
      tmo_d    = '0;
      firstAdv = (idx_q == IDX_HDR);
      if (idx_q != IDX_END) idx_d = idx_q + 4'd1;
    end else if (idx_q != IDX_HDR) begin
      if (tmo_q == TMO_LAST) begin
        idx_d = IDX_HDR;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Clearing first, then adding, lets a packet landing on the snapshot cycle seed the new totals.
  always_comb begin
    accX_d = accX_q;
    accY_d = accY_q;
    btn_d  = btn_q;
    if (firstAdv) begin
      accX_d = '0;
      accY_d = '0;
    end
    if (pktDone) begin
      accX_d = satAdd(accX_d, dx);
      accY_d = satAdd(accY_d, dy);
      btn_d  = btn;
    end
  end

`ifdef MOUSE_WHEEL_EN
  logic signed [3:0] wheel;
  logic signed [3:0] accW_q, accW_d, snapW_q;

  function automatic logic signed [3:0] satAdd4(input logic signed [3:0] a,
                                                input logic signed [3:0] d);
    logic [4:0] sum;
    sum = {a[3], a} + {d[3], d};
    if (sum[4] != sum[3]) return sum[4] ? 4'sh8 : 4'sh7;
    return sum[3:0];
  endfunction

  always_comb begin
    accW_d = accW_q;
    if (firstAdv) accW_d = '0;
    if (pktDone) accW_d = satAdd4(accW_d, wheel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accW_q  <= '0;
      snapW_q <= '0;
    end else begin
      accW_q <= accW_d;
      if (firstAdv) snapW_q <= accW_q;
    end
  end
`endif

  always_comb begin
    mdata_d = NIB_IDLE;
    case (idx_q)
      IDX_BTN: mdata_d = {1'b1, ~snapBtn_q};
      IDX_Y2:  mdata_d = snapY_q[11:8];
      IDX_Y1:  mdata_d = snapY_q[7:4];
      IDX_Y0:  mdata_d = snapY_q[3:0];
      IDX_X2:  mdata_d = snapX_q[11:8];
      IDX_X1:  mdata_d = snapX_q[7:4];
      IDX_X0:  mdata_d = snapX_q[3:0];
`ifdef MOUSE_WHEEL_EN
      IDX_END: mdata_d = snapW_q;
`endif
      default: mdata_d = NIB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accX_q    <= '0;
      accY_q    <= '0;
      btn_q     <= 3'b000;
      snapX_q   <= 12'h000;
      snapY_q   <= 12'h000;
      snapBtn_q <= 3'b000;
      rdSync_q  <= 1'b0;
      rdDly_q   <= 1'b0;
      idx_q     <= IDX_HDR;
      tmo_q     <= '0;
      mdata_q   <= NIB_IDLE;
      err_q     <= 1'b0;
    end else begin
      accX_q   <= accX_d;
      accY_q   <= accY_d;
      btn_q    <= btn_d;
      rdSync_q <= rdmsel;
      rdDly_q  <= rdSync_q;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      mdata_q  <= mdata_d;
      err_q    <= syncErr;
      if (firstAdv) begin
        snapX_q   <= clampSnap(accX_q);
        snapY_q   <= clampSnap(accY_q);
        snapBtn_q <= btn_q;
      end
    end
  end

  assign mdata      = mdata_q;
  assign packet_err = err_q;

endmodule

// File: tb/tb_sam_mouse_interface.sv
// Self-checking bench for sam_mouse_interface (default build: 3-byte packets, no wheel).
module tb_sam_mouse_interface;

  localparam int TIMEOUT_CYCLES = 600;
  localparam int ACC_MAX = 2047;
  localparam int ACC_MIN = -2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_byte_valid = 1'b0;
  logic       rdmsel = 1'b0;
  logic [3:0] mdata;
  logic       packet_err;

  always #5 clk = ~clk;

  sam_mouse_interface #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ACC_W(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_byte       (ps2_byte),
    .ps2_byte_valid (ps2_byte_valid),
    .rdmsel         (rdmsel),
    .mdata          (mdata),
    .packet_err     (packet_err)
  );

  int checks = 0;
  int failures = 0;
  int errPulses = 0;

  always @(negedge clk) if (packet_err === 1'b1) errPulses++;

  // Behavioural model: running totals, last buttons, and the values captured at the first read.
  int         mAccX, mAccY, mSnapX, mSnapY;
  logic [2:0] mBtn, mSnapBtn;

  function automatic int sat(input int v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  function automatic logic [3:0] expNibble(input int k);
    logic [11:0] x, y;
    x = 12'(mSnapX);
    y = 12'(mSnapY);
    case (k)
      1: return {1'b1, ~mSnapBtn};
      2: return y[11:8];
      3: return y[7:4];
      4: return y[3:0];
      5: return x[11:8];
      6: return x[7:4];
      7: return x[3:0];
      default: return 4'hF;
    endcase
  endfunction

  task automatic modelReset();
    mAccX = 0; mAccY = 0; mSnapX = 0; mSnapY = 0;
    mBtn = 3'b000; mSnapBtn = 3'b000;
  endtask

  task automatic modelPacket(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mAccX = sat(mAccX + dx);
    mAccY = sat(mAccY + dy);
    mBtn  = b0[2:0];
  endtask

  task automatic modelSnapshot();
    mSnapX = mAccX; mSnapY = mAccY; mSnapBtn = mBtn;
    mAccX = 0; mAccY = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; rdmsel = 1'b0; ps2_byte_valid = 1'b0;
    waitCycles(3);
    rst = 1'b0;
    modelReset();
    waitCycles(1);
  endtask

  task automatic sendByte(input logic [7:0] b);
    ps2_byte = b; ps2_byte_valid = 1'b1;
    waitCycles(1);
    ps2_byte_valid = 1'b0;
    waitCycles(1);
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    sendByte(b0); sendByte(b1); sendByte(b2);
    modelPacket(b0, b1, b2);
  endtask

  task automatic readStrobe(output logic [3:0] nib);
    rdmsel = 1'b1;
    waitCycles(3);
    @(negedge clk) nib = mdata;
    @(posedge clk);
    #1 rdmsel = 1'b0;
    waitCycles(5);
  endtask

  // Reads from index 'first' to the end, then idles long enough for the sequence to restart.
  task automatic readSequence(input string tag, input int first);
    logic [3:0] nib, exp;
    for (int k = first; k <= 8; k++) begin
      exp = expNibble(k);
      readStrobe(nib);
      checkOutput($sformatf("%s idx%0d", tag, k), 32'(nib), 32'(exp));
      if (k == 0) modelSnapshot();
    end
    waitCycles(TIMEOUT_CYCLES + 10);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [35:0] nibs;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] nib;
    int e0, nBad, n;
    logic [7:0] b0, b1, b2;

    vecs[0] = '{8'h28, 8'h05, 8'hFD, 36'hFFFFD005F};
    vecs[1] = '{8'h09, 8'h01, 8'h01, 36'hFE001001F};
    vecs[2] = '{8'h3A, 8'h00, 8'h80, 36'hFDF80F00F};
    vecs[3] = '{8'hCC, 8'h7F, 8'h7F, 36'hFB000000F};
    vecs[4] = '{8'h48, 8'h10, 8'h20, 36'hFF020000F};

    doReset();
    @(negedge clk);
    checkOutput("reset mdata", 32'(mdata), 32'hF);
    checkOutput("reset packet_err", 32'(packet_err), 32'h0);
    waitCycles(1);

    e0 = errPulses;
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].b0, vecs[v].b1, vecs[v].b2);
      for (int k = 0; k <= 8; k++) begin
        readStrobe(nib);
        checkOutput($sformatf("vec%0d idx%0d", v, k), 32'(nib), 32'(vecs[v].nibs[35-4*k -: 4]));
        if (k == 0) modelSnapshot();
      end
      waitCycles(TIMEOUT_CYCLES + 10);
    end
    checkOutput("table no sync err", 32'(errPulses - e0), 32'h0);

    // Sync error then a valid left-button packet
    doReset();
    e0 = errPulses;
    sendByte(8'h00);
    waitCycles(2);
    checkOutput("sync err pulses", 32'(errPulses - e0), 32'h1);
    applyStimulus(8'h09, 8'h01, 8'h01);
    readSequence("after sync err", 0);

    // Positive and negative saturation, then cleared totals
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(8'h08, 8'hFF, 8'h00);
    readStrobe(nib); modelSnapshot();
    for (int k = 1; k <= 7; k++) readStrobe(nib);
    checkOutput("sat pos x lo", 32'(nib), 32'hF);
    waitCycles(TIMEOUT_CYCLES + 10);
    readSequence("after sat", 0);
    for (int i = 0; i < 20; i++) applyStimulus(8'h18, 8'h00, 8'h00);
    readSequence("sat neg", 0);

    // Timeout: short idle keeps the index, long idle restarts it
    doReset();
    applyStimulus(8'h09, 8'h01, 8'h01);
    readStrobe(nib); checkOutput("tmo hdr", 32'(nib), 32'hF);
    readStrobe(nib); checkOutput("tmo btn", 32'(nib), 32'hE);
    waitCycles(TIMEOUT_CYCLES - 50);
    readStrobe(nib); checkOutput("no tmo y2", 32'(nib), 32'h0);
    waitCycles(TIMEOUT_CYCLES + 20);
    readStrobe(nib); checkOutput("after tmo hdr", 32'(nib), 32'hF);
    readStrobe(nib); checkOutput("after tmo btn", 32'(nib), 32'hE);

    // Reset mid-packet discards the partial packet
    waitCycles(TIMEOUT_CYCLES + 10);
    sendByte(8'h08); sendByte(8'h7F);
    doReset();
    applyStimulus(8'h28, 8'h05, 8'hFD);
    readSequence("post reset", 0);

    // Packet completing on the same cycle as the first read advance
    doReset();
    applyStimulus(8'h09, 8'h03, 8'h02);
    sendByte(8'h0A); sendByte(8'h07);
    rdmsel = 1'b1;
    waitCycles(3);
    @(negedge clk) nib = mdata;
    checkOutput("coinc hdr", 32'(nib), 32'hF);
    @(posedge clk);
    #1 rdmsel = 1'b0;
    @(posedge clk);
    #1 ps2_byte = 8'h04; ps2_byte_valid = 1'b1;
    @(posedge clk);
    #1 ps2_byte_valid = 1'b0;
    modelSnapshot();
    modelPacket(8'h0A, 8'h07, 8'h04);
    waitCycles(5);
    readSequence("coinc old", 1);
    readSequence("coinc new", 0);

    // Randomized packets with occasional sync errors
    doReset();
    for (int s = 0; s < 20; s++) begin
      e0 = errPulses;
      nBad = 0;
      n = $urandom_range(0, 6);
      for (int p = 0; p < n; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          sendByte(8'($urandom) & 8'hF7);
          nBad++;
        end
        b0 = 8'($urandom) | 8'h08;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        applyStimulus(b0, b1, b2);
      end
      waitCycles(2);
      checkOutput($sformatf("rand%0d sync errs", s), 32'(errPulses - e0), 32'(nBad));
      readSequence($sformatf("rand%0d", s), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
